// File: rtl/apb_uart_fifo_pkg.sv
// apb_uart_fifo_pkg: register map, status/control bit positions and UART FSM states
package apb_uart_fifo_pkg;
  localparam logic [4:0] ADDR_DATA   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_DIV    = 5'h0C;
  localparam logic [4:0] ADDR_INT_EN = 5'h10;
  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_OVR      = 8;
  localparam int ST_FE       = 9;
  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_TX_FLUSH = 2;
  localparam int CTRL_RX_FLUSH = 3;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with flush; a pop frees room for a same-cycle push when full
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic w_push, w_pop;
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  // storage write; the extra pointer bit distinguishes full from empty
  always_ff @(posedge i_clk)
    if (w_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
endmodule

// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB-programmable 8N1 UART with TX/RX FIFOs, baud divider and level interrupt
module apb_uart_fifo
  import apb_uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [4:0]            PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  rx,
  output logic                  tx,
  output logic                  irq
);
  logic r_pready, r_pslverr, r_irq;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic r_tx_en, r_rx_en, r_fe, r_ovr;
  logic [3:0] r_int_en;
  logic [DIV_WIDTH-1:0] r_div, r_baud_cnt;
  tx_state_t r_tx_st, w_tx_nxt;
  rx_state_t r_rx_st, w_rx_nxt;
  logic [3:0] r_tx_tcnt, r_rx_tcnt;
  logic [2:0] r_tx_bit, r_rx_bit;
  logic [7:0] r_tx_shift, r_rx_shift;
  logic r_rx_s1, r_rx_s2, r_rx_d;
  logic w_setup, w_wr, w_rd, w_err, w_tick, w_unused;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [9:0] w_status;
  logic w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty, w_tx_bit_end;
  logic w_rx_push, w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty, w_rx_bit_end, w_rx_done;
  logic [7:0] w_tx_rdata, w_rx_rdata;
  assign w_unused = ^PWDATA;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;
  assign PRDATA  = r_prdata;
  assign irq     = r_irq;
  assign tx      = r_tx_st == TX_START ? 1'b0 : r_tx_st == TX_DATA ? r_tx_shift[0] : 1'b1;
  assign w_setup = PSEL & PENABLE & ~r_pready;
  assign w_wr    = PSEL & PENABLE & r_pready & PWRITE;
  assign w_rd    = PSEL & PENABLE & r_pready & ~PWRITE;
  assign w_status = {r_fe, r_ovr, 4'b0, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
  // a failed DATA access was already flagged at setup, so it must not touch the FIFO
  assign w_tx_push  = w_wr && PADDR == ADDR_DATA && !r_pslverr;
  assign w_rx_pop   = w_rd && PADDR == ADDR_DATA && !r_pslverr;
  assign w_tx_flush = w_wr && PADDR == ADDR_CTRL && PWDATA[CTRL_TX_FLUSH];
  assign w_rx_flush = w_wr && PADDR == ADDR_CTRL && PWDATA[CTRL_RX_FLUSH];
  assign w_tick     = r_baud_cnt == r_div;
  assign w_tx_bit_end = w_tick && r_tx_tcnt == 4'd15;
  assign w_rx_bit_end = w_tick && r_rx_tcnt == 4'd15;
  assign w_rx_done  = r_rx_st == RX_STOP && w_rx_bit_end;
  assign w_rx_push  = w_rx_done & ~w_rx_full;
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(PCLK), .i_rst_n(PRESETn), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_flush(w_tx_flush),
    .i_wdata(PWDATA[7:0]), .o_rdata(w_tx_rdata), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(PCLK), .i_rst_n(PRESETn), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_flush(w_rx_flush),
    .i_wdata(r_rx_shift), .o_rdata(w_rx_rdata), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );
  // read data and error decode, evaluated in the wait cycle so PRDATA is registered for completion
  always_comb begin
    w_rdata = '0;
    w_err = 1'b0;
    case (PADDR)
      ADDR_DATA: begin
        w_err = PWRITE ? w_tx_full : w_rx_empty;
        w_rdata[7:0] = (PWRITE || w_rx_empty) ? 8'h00 : w_rx_rdata;
      end
      ADDR_STATUS: w_rdata[9:0] = PWRITE ? 10'd0 : w_status;
      ADDR_CTRL:   w_rdata[1:0] = PWRITE ? 2'd0 : {r_rx_en, r_tx_en};
      ADDR_DIV:    w_rdata[DIV_WIDTH-1:0] = PWRITE ? '0 : r_div;
      ADDR_INT_EN: w_rdata[3:0] = PWRITE ? 4'd0 : r_int_en;
      default: ;
    endcase
  end
  // APB handshake with a single wait state; response is visible only in the completion cycle
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= w_setup;
      r_pslverr <= w_setup & w_err;
      if (w_setup) r_prdata <= w_rdata;
    end
  // control registers, sticky error flags and registered interrupt
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_tx_en  <= 1'b0;
      r_rx_en  <= 1'b0;
      r_div    <= DIV_RESET;
      r_int_en <= 4'd0;
      r_fe     <= 1'b0;
      r_ovr    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && PADDR == ADDR_CTRL) {r_rx_en, r_tx_en} <= {PWDATA[CTRL_RX_EN], PWDATA[CTRL_TX_EN]};
      if (w_wr && PADDR == ADDR_DIV) r_div <= PWDATA[DIV_WIDTH-1:0];
      if (w_wr && PADDR == ADDR_INT_EN) r_int_en <= PWDATA[3:0];
      r_ovr <= (r_ovr & ~(w_wr && PADDR == ADDR_STATUS && PWDATA[ST_OVR])) | (w_rx_done & w_rx_full);
      r_fe  <= (r_fe & ~(w_wr && PADDR == ADDR_STATUS && PWDATA[ST_FE])) | (w_rx_done & ~r_rx_s2);
      r_irq <= |(r_int_en & {r_fe, r_ovr, ~w_rx_empty, w_tx_empty});
    end
  // baud tick every DIV+1 cycles, phase restarted by a DIV write
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_baud_cnt <= '0;
    else r_baud_cnt <= (w_tick || (w_wr && PADDR == ADDR_DIV)) ? '0 : r_baud_cnt + DIV_WIDTH'(1);
  // TX state register
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_tx_st <= TX_IDLE;
    else r_tx_st <= w_tx_nxt;
  // TX next state; tx_en is only consulted between frames
  always_comb begin
    w_tx_nxt = r_tx_st;
    w_tx_pop = 1'b0;
    case (r_tx_st)
      TX_IDLE: if (r_tx_en && !w_tx_empty) begin
        w_tx_nxt = TX_START;
        w_tx_pop = 1'b1;
      end
      TX_START: if (w_tx_bit_end) w_tx_nxt = TX_DATA;
      TX_DATA: if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
      TX_STOP: if (w_tx_bit_end) begin
        w_tx_nxt = (r_tx_en && !w_tx_empty) ? TX_START : TX_IDLE;
        w_tx_pop = r_tx_en && !w_tx_empty;
      end
      default: w_tx_nxt = TX_IDLE;
    endcase
  end
  // TX tick counter, bit counter and LSB-first shifter
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_tx_tcnt  <= 4'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
    end else begin
      r_tx_tcnt <= (w_tx_nxt != r_tx_st) ? 4'd0 : r_tx_tcnt + {3'd0, w_tick};
      r_tx_bit  <= r_tx_st != TX_DATA ? 3'd0 : r_tx_bit + {2'd0, w_tx_bit_end};
      if (w_tx_pop) r_tx_shift <= w_tx_rdata;
      else if (r_tx_st == TX_DATA && w_tx_bit_end) r_tx_shift <= r_tx_shift >> 1;
    end
  // two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) {r_rx_s1, r_rx_s2, r_rx_d} <= 3'b111;
    else {r_rx_s1, r_rx_s2, r_rx_d} <= {rx, r_rx_s1, r_rx_s2};
  // RX state register
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_rx_st <= RX_IDLE;
    else r_rx_st <= w_rx_nxt;
  // RX next state; start bit is re-checked at its midpoint to reject glitches
  always_comb begin
    w_rx_nxt = r_rx_st;
    case (r_rx_st)
      RX_IDLE: if (r_rx_en && r_rx_d && !r_rx_s2) w_rx_nxt = RX_START;
      RX_START: if (w_tick && r_rx_tcnt == 4'd7) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA: if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP: if (w_rx_bit_end) w_rx_nxt = RX_IDLE;
      default: w_rx_nxt = RX_IDLE;
    endcase
  end
  // RX tick counter, bit counter and mid-bit sampling shifter
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_rx_tcnt  <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      r_rx_tcnt <= (w_rx_nxt != r_rx_st) ? 4'd0 : r_rx_tcnt + {3'd0, w_tick};
      r_rx_bit  <= r_rx_st != RX_DATA ? 3'd0 : r_rx_bit + {2'd0, w_rx_bit_end};
      if (r_rx_st == RX_DATA && w_rx_bit_end) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
    end
endmodule

// File: doc/apb_uart_fifo.md
APB_UART_FIFO -- requirements
Module: apb_uart_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning APB data bus width (>=16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning TX and RX FIFO depth (power of 2, >=2).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, meaning baud divisor register width.
REQ-004 SHALL have parameter DIV_RESET, default 0, meaning reset value of the divisor register.
REQ-005 SHALL have ports PCLK in 1 (single clock) and PRESETn in 1 (reset is asynchronous and active-low).
REQ-006 SHALL have APB completer ports PSEL in 1, PENABLE in 1, PWRITE in 1, PADDR in 5, PWDATA in DATA_WIDTH, PRDATA out DATA_WIDTH, PREADY out 1, PSLVERR out 1.
REQ-007 SHALL have ports rx in 1 (serial in, idle high), tx out 1 (serial out, idle high), irq out 1 (level interrupt).

Function
REQ-008 The APB handshake SHALL register PREADY: it is 1 in the cycle after PSEL&PENABLE is seen with PREADY=0, and 0 otherwise, giving exactly one wait state per transfer.
REQ-009 Register side effects and PRDATA/PSLVERR SHALL take effect only in the completion cycle (PSEL&PENABLE&PREADY), once per transfer.
REQ-010 Map: 0x00 DATA (W pushes PWDATA[7:0] to TX FIFO; R pops RX FIFO); 0x04 STATUS (RO/W1C); 0x08 CTRL; 0x0C DIV; 0x10 INT_EN. Unmapped reads return 0 with no error.
REQ-011 STATUS SHALL be {[9] fe sticky, [8] ovr sticky, [7:4] reserved 0, [3] rx_full, [2] rx_empty, [1] tx_full, [0] tx_empty}; writing 1 to bit 8 or 9 clears it.
REQ-012 CTRL SHALL be [0] tx_en, [1] rx_en (R/W), [2] tx_flush, [3] rx_flush (write-1, self-clearing, read 0); a flush empties its FIFO in the completion cycle.
REQ-013 A DATA write with TX FIFO full SHALL drop the byte and assert PSLVERR; a DATA read with RX FIFO empty SHALL return 0 and assert PSLVERR.
REQ-014 The baud generator SHALL issue a 1-cycle tick every DIV+1 PCLK cycles, and SHALL restart its count when DIV is written; one bit period is 16 ticks.
REQ-015 The TX FSM SHALL have states IDLE, START, DATA, STOP; frame 8N1, LSB first.
REQ-016 TX SHALL leave IDLE when tx_en=1 and the FIFO is non-empty, popping on that transition; after STOP it returns to IDLE, or directly to START if a byte is pending.
REQ-017 Clearing tx_en SHALL take effect only after the current frame's STOP bit completes.
REQ-018 rx SHALL pass through a 2-flop synchroniser.
REQ-019 The RX FSM SHALL have states IDLE, START, DATA, STOP; a falling edge with rx_en=1 enters START.
REQ-020 In START, rx SHALL be sampled at tick 8; if it is high the start bit is a glitch and the FSM returns to IDLE.
REQ-021 Each data bit and the stop bit SHALL be sampled at the mid-bit tick.
REQ-022 If the stop bit samples 0, the byte SHALL still be stored and fe SHALL be set.
REQ-023 A received byte arriving with RX FIFO full SHALL be discarded and ovr SHALL be set.
REQ-024 Each FIFO SHALL accept a simultaneous push and pop when full (count unchanged); when empty only the push is accepted; pointers wrap modulo FIFO_DEPTH.
REQ-025 irq SHALL equal |(INT_EN[3:0] & {fe, ovr, ~rx_empty, tx_empty}), registered.

Reset
REQ-026 On PRESETn low, asynchronously: PREADY=0, PSLVERR=0, PRDATA=0, tx=1, irq=0, both FSMs=IDLE, FIFOs empty, fe=ovr=0, CTRL=0, INT_EN=0, DIV=DIV_RESET, baud counter=0, synchroniser flops=1.
REQ-027 A reset during a frame SHALL abort it with no partial byte stored.

Structure
REQ-028 A shared package SHALL hold the register offsets, STATUS/CTRL bit indices and the TX/RX FSM state enums.
REQ-029 The FIFO SHALL be one sub-module, uart_sync_fifo (params WIDTH, DEPTH; push/pop/flush/full/empty), instantiated twice.

Verification
REQ-030 DIV=0, tx_en=1, write 0x55 -> tx shows start bit 0 then 1,0,1,0,1,0,1,0 then stop bit 1, each 16 PCLK cycles wide; tx_empty returns to 1.
REQ-031 Loop tx to rx with DIV=3, tx_en=rx_en=1, write 0xA3, 0x0F -> DATA reads return 0xA3, then 0x0F, then 0 with PSLVERR=1.
REQ-032 Write 17 bytes with tx_en=0 and FIFO_DEPTH=16 -> 17th write gets PSLVERR=1, tx_full=1, only 16 bytes are transmitted after tx_en is set.
REQ-033 Receive 17 frames with no reads -> ovr=1, RX FIFO holds the first 16 bytes; writing STATUS=0x100 clears ovr.
REQ-034 Inject a 4-cycle low glitch on rx at DIV=0 -> no byte is stored; then send a frame with stop bit 0 -> fe=1 and the byte is stored; INT_EN=0x8 makes irq=1.
REQ-035 Assert PRESETn low mid-TX-frame -> tx=1 immediately, all status bits read 0x05 after release.
